// File: rtl/trig_rom_arbiter_if.sv
// Requester-side and ROM-side signals of the shared sin/cos ROM arbiter.
interface trig_arb_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]   req;
  logic [6*NREQ-1:0] angle_in;
  logic [8*NREQ-1:0] sin_out;
  logic [8*NREQ-1:0] cos_out;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   angle_err;
  logic              busy;
  logic              rom_rd;
  logic [5:0]        rom_addr;
  logic [7:0]        rom_sin;
  logic [7:0]        rom_cos;

  modport master (output req, angle_in, rom_sin, rom_cos,
                  input  sin_out, cos_out, done, angle_err, busy, rom_rd, rom_addr);
  modport slave  (input  req, angle_in, rom_sin, rom_cos,
                  output sin_out, cos_out, done, angle_err, busy, rom_rd, rom_addr);
endinterface

// File: rtl/trig_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sin/cos ROM among NREQ angle consumers.
// Optional TRIG_ARB_CACHE_EN: a repeated angle on a slot completes from the stored result.

module trig_rom_slot (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       wr,
  input  logic       pulse,
  input  logic       err_set,
  input  logic [7:0] rom_sin,
  input  logic [7:0] rom_cos,
  output logic [7:0] sin_q,
  output logic [7:0] cos_q,
  output logic       done,
  output logic       err
);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sin_q <= '0;
      cos_q <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= wr | pulse;
      if (wr) begin
        sin_q <= rom_sin;
        cos_q <= rom_cos;
      end
      if (err_set) err <= 1'b1;
    end
  end
endmodule

module trig_rom_arbiter #(
  parameter int NREQ        = 4,
  parameter int ROM_LAT     = 1,
  parameter int ANGLE_COUNT = 45
) (
  input logic       Clk,
  input logic       Reset,
  trig_arb_if.slave bus
);
  localparam int            IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0]    WAIT_LAST = 3'(ROM_LAT - 2);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
  state_t state, state_nx;

  logic [IW-1:0]        ptr, gnt, pick, idx;
  logic [5:0]           addr_q, pick_ang, pick_addr;
  logic [2:0]           wcnt;
  logic                 any_req, pick_oor, grant, hit, hit_c, cap, rom_rd;
  logic [NREQ-1:0][5:0] ang_v;
  logic [NREQ-1:0][7:0] sin_v, cos_v;
  logic [NREQ-1:0]      slot_done, slot_err;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IW'(1);
  endfunction

  assign ang_v = bus.angle_in;

  // First requester at or after ptr, searching circularly.
  always_comb begin
    pick    = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  assign pick_ang  = ang_v[pick];
  assign pick_oor  = int'(pick_ang) >= ANGLE_COUNT;
  assign pick_addr = pick_oor ? 6'd0 : pick_ang;

`ifdef TRIG_ARB_CACHE_EN
  logic [NREQ-1:0]      cvld;
  logic [NREQ-1:0][5:0] cang;
  assign hit_c = cvld[pick] && (cang[pick] == pick_addr);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cvld <= '0;
      cang <= '0;
    end else if (cap) begin
      cvld[gnt] <= 1'b1;
      cang[gnt] <= addr_q;
    end
  end
`else
  assign hit_c = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    hit      = 1'b0;
    cap      = 1'b0;
    rom_rd   = 1'b0;
    case (state)
      IDLE: if (any_req) begin
        grant = 1'b1;
        // A cache hit completes in the grant cycle and never touches the ROM.
        if (hit_c) hit = 1'b1;
        else       state_nx = ISSUE;
      end
      ISSUE: begin
        rom_rd   = 1'b1;
        state_nx = (ROM_LAT == 1) ? CAPTURE : WAIT;
      end
      WAIT:    if (wcnt == WAIT_LAST) state_nx = CAPTURE;
      CAPTURE: begin
        cap      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr    <= '0;
      gnt    <= '0;
      addr_q <= '0;
      wcnt   <= '0;
    end else begin
      if (grant) begin
        gnt    <= pick;
        addr_q <= pick_addr;
      end
      if (hit)      ptr <= next_idx(pick);
      else if (cap) ptr <= next_idx(gnt);
      wcnt <= (state == WAIT) ? wcnt + 3'd1 : 3'd0;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    trig_rom_slot u_slot (
      .Clk     (Clk),
      .Reset   (Reset),
      .wr      (cap && gnt == IW'(i)),
      .pulse   (hit && pick == IW'(i)),
      .err_set (grant && pick_oor && pick == IW'(i)),
      .rom_sin (bus.rom_sin),
      .rom_cos (bus.rom_cos),
      .sin_q   (sin_v[i]),
      .cos_q   (cos_v[i]),
      .done    (slot_done[i]),
      .err     (slot_err[i])
    );
  end

  assign bus.sin_out   = sin_v;
  assign bus.cos_out   = cos_v;
  assign bus.done      = slot_done;
  assign bus.angle_err = slot_err;
  assign bus.busy      = (state != IDLE);
  assign bus.rom_rd    = rom_rd;
  assign bus.rom_addr  = addr_q;
endmodule

// File: tb/tb_trig_rom_arbiter.sv
// Directed and randomized bench for trig_rom_arbiter (ROM_LAT=1 and ROM_LAT=3 instances).
module tb_trig_rom_arbiter;
  localparam int NREQ = 4;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  localparam int ACNT = 45;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  trig_arb_if #(.NREQ(NREQ)) bus1 ();
  trig_arb_if #(.NREQ(NREQ)) bus3 ();

  trig_rom_arbiter #(.NREQ(NREQ), .ROM_LAT(LAT1), .ANGLE_COUNT(ACNT)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1));
  trig_rom_arbiter #(.NREQ(NREQ), .ROM_LAT(LAT3), .ANGLE_COUNT(ACNT)) dut3 (
    .Clk(Clk), .Reset(Reset), .bus(bus3));

  logic [NREQ-1:0] req1, req3;
  logic [5:0]      ang1 [NREQ];
  logic [5:0]      ang3 [NREQ];
  assign bus1.req      = req1;
  assign bus1.angle_in = {ang1[3], ang1[2], ang1[1], ang1[0]};
  assign bus3.req      = req3;
  assign bus3.angle_in = {ang3[3], ang3[2], ang3[1], ang3[0]};

  // ROM contents: arbitrary but distinct per index.
  function automatic logic [7:0] sin_w(input logic [5:0] a);
    return 8'(int'(a) * 37 + 11);
  endfunction
  function automatic logic [7:0] cos_w(input logic [5:0] a);
    return 8'(int'(a) * 53 + 200);
  endfunction

  // Synchronous ROMs; data is undefined unless a read was issued LAT cycles ago.
  logic [15:0] rom1_q;
  logic [15:0] rom3_p [3];
  always @(posedge Clk)
    rom1_q <= bus1.rom_rd ? {sin_w(bus1.rom_addr), cos_w(bus1.rom_addr)} : 16'hxxxx;
  always @(posedge Clk) begin
    rom3_p[0] <= bus3.rom_rd ? {sin_w(bus3.rom_addr), cos_w(bus3.rom_addr)} : 16'hxxxx;
    rom3_p[1] <= rom3_p[0];
    rom3_p[2] <= rom3_p[1];
  end
  assign bus1.rom_sin = rom1_q[15:8];
  assign bus1.rom_cos = rom1_q[7:0];
  assign bus3.rom_sin = rom3_p[2][15:8];
  assign bus3.rom_cos = rom3_p[2][7:0];

  // Transaction-level model of the LAT1 instance: a service occupies LAT+2 cycles.
  int              m_rem, m_ptr, m_gnt;
  logic [5:0]      m_addr;
  logic [7:0]      m_sin [NREQ];
  logic [7:0]      m_cos [NREQ];
  logic [NREQ-1:0] m_err, m_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_ptr = 0; m_gnt = 0; m_addr = '0; m_err = '0; m_done = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_sin[i] = '0;
      m_cos[i] = '0;
    end
  endtask

  task automatic model_step();
    m_done = '0;
    if (m_rem != 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_sin[m_gnt]  = sin_w(m_addr);
        m_cos[m_gnt]  = cos_w(m_addr);
        m_done[m_gnt] = 1'b1;
        m_ptr = (m_gnt + 1) % NREQ;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (req1[j]) begin
          m_gnt = j;
          if (int'(ang1[j]) >= ACNT) begin
            m_addr   = '0;
            m_err[j] = 1'b1;
          end else m_addr = ang1[j];
          m_rem = LAT1 + 1;
          break;
        end
      end
    end
  endtask

  task automatic check_dut1();
    chk("d1_done", bus1.done, m_done);
    chk("d1_busy", bus1.busy, m_rem != 0);
    chk("d1_rom_rd", bus1.rom_rd, m_rem == LAT1 + 1);
    if (m_rem == LAT1 + 1) chk("d1_rom_addr", bus1.rom_addr, m_addr);
    chk("d1_angle_err", bus1.angle_err, m_err);
    chk("d1_sin_out", bus1.sin_out, {m_sin[3], m_sin[2], m_sin[1], m_sin[0]});
    chk("d1_cos_out", bus1.cos_out, {m_cos[3], m_cos[2], m_cos[1], m_cos[0]});
  endtask

  task automatic tick();
    @(posedge Clk);
    if (!Reset) model_step();
    @(negedge Clk);
    check_dut1();
  endtask

  function automatic logic [5:0] rand_angle();
    if ($urandom_range(0, 7) == 0) return 6'($urandom_range(45, 63));
    return 6'($urandom_range(0, 44));
  endfunction

  int              n;
  int              wt [NREQ];
  logic [NREQ-1:0] seen;

  initial begin
    Reset = 1'b1;
    req1  = '0;
    req3  = '0;
    for (int i = 0; i < NREQ; i++) begin
      ang1[i] = '0;
      ang3[i] = '0;
      wt[i]   = 0;
    end
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    check_dut1();
    chk("rst_d3_busy", bus3.busy, 0);
    chk("rst_d3_rom_rd", bus3.rom_rd, 0);
    chk("rst_d3_rom_addr", bus3.rom_addr, 0);
    chk("rst_d3_sin", bus3.sin_out, 0);
    Reset = 1'b0;

    // Single request, angle 11.
    req1 = 4'b0001; ang1[0] = 6'd11;
    tick();
    chk("single_rd", bus1.rom_rd, 1);
    chk("single_addr", bus1.rom_addr, 11);
    tick();
    chk("single_done_early", bus1.done, 0);
    tick();
    chk("single_done", bus1.done, 4'b0001);
    chk("single_sin", bus1.sin_out[7:0], sin_w(6'd11));
    chk("single_cos", bus1.cos_out[7:0], cos_w(6'd11));
    req1 = '0;

    // Round robin from ptr=0 with all four requesting.
    Reset = 1'b1; model_reset(); tick(); Reset = 1'b0;
    req1 = 4'b1111;
    ang1[0] = 6'd0; ang1[1] = 6'd5; ang1[2] = 6'd10; ang1[3] = 6'd15;
    for (int s = 0; s < 5; s++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (bus1.done == '0 && n < 10);
      chk("rr_order", bus1.done, 4'b0001 << (s % 4));
      chk("rr_gap", n, 3);
    end
    chk("rr_sin", bus1.sin_out, {sin_w(6'd15), sin_w(6'd10), sin_w(6'd5), sin_w(6'd0)});
    chk("rr_cos", bus1.cos_out, {cos_w(6'd15), cos_w(6'd10), cos_w(6'd5), cos_w(6'd0)});
    req1 = '0;

    // Out-of-range angle clamps to 0 and sets a sticky error.
    req1 = 4'b0010; ang1[1] = 6'd50;
    tick();
    chk("oor_rd", bus1.rom_rd, 1);
    chk("oor_addr", bus1.rom_addr, 0);
    chk("oor_err", bus1.angle_err, 4'b0010);
    tick(); tick();
    chk("oor_done", bus1.done, 4'b0010);
    chk("oor_slot", bus1.sin_out[15:8], sin_w(6'd0));
    req1 = '0;
    repeat (4) tick();
    chk("oor_sticky", bus1.angle_err, 4'b0010);

    // Drop after grant still completes.
    req1 = 4'b0100; ang1[2] = 6'd20;
    tick();
    req1[2] = 1'b0;
    tick(); tick();
    chk("drop_after_grant", bus1.done, 4'b0100);

    // Requester 0 drops while 3 is being served and is never served.
    req1 = 4'b1001; ang1[3] = 6'd7; ang1[0] = 6'd9;
    seen = '0;
    tick(); seen |= bus1.done;
    req1[0] = 1'b0;
    tick(); seen |= bus1.done;
    tick(); seen |= bus1.done;
    chk("drop_served3", bus1.done, 4'b1000);
    req1 = '0;
    repeat (4) begin tick(); seen |= bus1.done; end
    chk("drop_before_grant", seen[0], 0);

    // Randomized traffic against the model, with a reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        Reset = 1'b1; model_reset(); req1 = '0;
        for (int i = 0; i < NREQ; i++) wt[i] = 0;
        tick();
        Reset = 1'b0;
      end
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req1[i] && !bus1.done[i]) wt[i]++;
        if (req1[i] && (bus1.done[i] || wt[i] > 12)) begin
          chk("starve", wt[i] <= 12, 1);
          wt[i] = 0;
        end
        if (req1[i]) begin
          if (m_done[i]) req1[i] = ($urandom_range(0, 3) == 0);
          else if ($urandom_range(0, 29) == 0) req1[i] = 1'b0;
          if ($urandom_range(0, 9) == 0) ang1[i] = rand_angle();
        end else if ($urandom_range(0, 2) == 0) begin
          req1[i] = 1'b1;
          ang1[i] = rand_angle();
        end
        if (!req1[i]) wt[i] = 0;
      end
    end
    req1 = '0;

    // ROM_LAT=3 instance: latency, then reset during WAIT.
    req3 = 4'b0001; ang3[0] = 6'd20;
    tick();
    chk("l3_rd", bus3.rom_rd, 1);
    chk("l3_addr", bus3.rom_addr, 20);
    chk("l3_busy", bus3.busy, 1);
    tick();
    chk("l3_wait_rd", bus3.rom_rd, 0);
    tick(); tick();
    chk("l3_done_early", bus3.done, 0);
    tick();
    chk("l3_done", bus3.done, 4'b0001);
    chk("l3_sin", bus3.sin_out[7:0], sin_w(6'd20));
    chk("l3_cos", bus3.cos_out[7:0], cos_w(6'd20));
    req3 = '0;
    tick();
    req3 = 4'b0010; ang3[1] = 6'd30;
    tick();
    chk("l3_rd2", bus3.rom_rd, 1);
    tick();
    chk("l3_in_wait", bus3.busy, 1);
    Reset = 1'b1; model_reset();
    #1;
    chk("l3_rst_busy", bus3.busy, 0);
    chk("l3_rst_rd", bus3.rom_rd, 0);
    chk("l3_rst_done", bus3.done, 0);
    chk("l3_rst_addr", bus3.rom_addr, 0);
    chk("l3_rst_sin", bus3.sin_out, 0);
    chk("l3_rst_cos", bus3.cos_out, 0);
    chk("l3_rst_err", bus3.angle_err, 0);
    req3 = 4'b0100; ang3[2] = 6'd33;
    tick();
    Reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) chk("l3_post_rst_addr", bus3.rom_addr, 33);
      chk("l3_post_rst_done", bus3.done, (k == 5) ? 4'b0100 : 4'b0000);
    end
    chk("l3_post_rst_sin", bus3.sin_out[23:16], sin_w(6'd33));
    req3 = '0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trig_rom_arbiter.md
# trig_rom_arbiter

Shares one synchronous sine/cosine lookup ROM among several angle consumers: both tanks' motion logic and the bullet launch logic. Each requester raises a level request with a 6-bit angle index. The arbiter grants requesters round-robin, drives the ROM address, and captures the sign-magnitude sin/cos pair into that requester's private output registers. A one-cycle done pulse marks each fresh result. The block sits between the tank/bullet modules and the trig ROM, in the Clk domain, ahead of each frame_clk update.

## Interface
- NREQ, 4, number of requesters (2..8); index 0 = tank1, 1 = tank2, 2/3 = bullets
- ROM_LAT, 1, cycles from rom_rd to valid rom_sin/rom_cos (1..4)
- ANGLE_COUNT, 45, valid angle indices 0..ANGLE_COUNT-1 (4° per step)
- Clk  in  1  system clock; all logic on posedge
- Reset  in  1  asynchronous, active-high; clears every register immediately
- req  in  NREQ  level request per requester; held until matching done
- angle_in  in  6*NREQ  angle of requester i at bits [6i+5:6i]
- rom_rd  out  1  one-cycle ROM read strobe
- rom_addr  out  6  ROM address, valid while rom_rd=1
- rom_sin, rom_cos  in  8 each  ROM data, bit7 = sign, bits6:0 = magnitude
- sin_out, cos_out  out  8*NREQ  latched result per requester, at bits [8i+7:8i]
- done  out  NREQ  one-cycle pulse when requester i's sin_out/cos_out are updated
- busy  out  1  high whenever the FSM is not in IDLE
- angle_err  out  NREQ  sticky; set when requester i was served with an out-of-range angle

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - If any req bit is set, pick the first set bit at or after ptr, searching circularly.
  - Latch the winner index as gnt and its angle as addr_q, then go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE: rom_rd=1 and rom_addr=addr_q for exactly one cycle, then go to WAIT.
  - If ROM_LAT=1, skip WAIT and go straight to CAPTURE.
- WAIT: count ROM_LAT-1 cycles, then go to CAPTURE.
- CAPTURE:
  - Write rom_sin/rom_cos into slot gnt.
  - Pulse done[gnt].
  - Set ptr = (gnt+1) mod NREQ.
  - Return to IDLE.
- Angle range: if the latched angle ≥ ANGLE_COUNT, use addr_q = 0 and set angle_err[gnt]. The ROM is never addressed outside 0..ANGLE_COUNT-1.
- angle_in is sampled only in IDLE at grant. Changes after grant affect only the next request.
- Deassertion:
  - If req[i] drops after grant, the transaction still completes and done[i] still pulses.
  - If req[i] drops before grant, requester i is not served.
- If req[i] is still high after its done, it re-enters arbitration normally. With round-robin it waits behind the other active requesters.
- sin_out/cos_out slots not being written hold their values.
- No arithmetic is performed on ROM data; it passes through unchanged.

## Timing
- Reset values:
  - state = IDLE, ptr = 0, gnt = 0, addr_q = 0.
  - rom_rd = 0, rom_addr = 0, busy = 0.
  - done = 0, angle_err = 0.
  - All sin_out and cos_out slots = 8'h00.
- Latency, req seen in IDLE at cycle t:
  - rom_rd high at t+1.
  - done pulses at t+ROM_LAT+2; with ROM_LAT=1 that is t+3.
- Throughput: one service per ROM_LAT+2 cycles. Back-to-back requesters are granted in the IDLE cycle directly after CAPTURE.
- Worst-case wait for one requester with all NREQ active: NREQ*(ROM_LAT+2) cycles. This is far below one frame_clk period.
- Simultaneous requests are resolved by ptr only. There is no fixed priority.
- Reset mid-transaction: the in-flight read is discarded and no done pulse is issued. Arbitration restarts from ptr = 0.
- done and sin_out/cos_out update on the same clock edge. A consumer may sample the data on the cycle done is high.

## Configuration
- TRIG_ARB_CACHE_EN defined:
  - Each slot also stores the last served angle plus a slot-valid bit, cleared by Reset.
  - At grant in IDLE, if the slot is valid and its stored angle equals angle_in, skip the ROM and go straight to CAPTURE with the stored data. done pulses at t+1, and rom_rd is not asserted.
  - Out-of-range angles are compared after clamping to 0.
- TRIG_ARB_CACHE_EN undefined: every grant performs a ROM read; no cache storage is built.

## Test plan
- Single request (ROM_LAT=1): after reset, req=4'b0001 with angle 11 → rom_rd pulses with rom_addr=11 at t+1; done[0] pulses at t+3; sin_out[7:0] and cos_out[7:0] equal the ROM words at index 11.
- Round-robin with all four requesting: req=4'b1111 held, angles 0/5/10/15 → services in order 0,1,2,3,0; one done pulse every 3 cycles; each slot holds its own pair.
- Out-of-range angle: req[1] with angle 50 → rom_addr=0; angle_err[1] goes high and stays high until Reset; slot 1 gets the index-0 data.
- Reset mid-operation: assert Reset during WAIT with ROM_LAT=3 → no done pulse; all outputs at reset values; after release, req=4'b0100 is served first.
- Drop and starvation check: req[2] drops one cycle after grant → done[2] still pulses; a requester that drops before grant is never served; with one requester held high continuously, the others are still each served within 4*(ROM_LAT+2) cycles.
- Cache (TRIG_ARB_CACHE_EN defined): req[0] with angle 7 twice → first service reads the ROM; second has no rom_rd and done[0] pulses 1 cycle after grant; changing angle to 8 reads the ROM again.
